branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor for the RISC-V core, sitting at the opposite end of the branch path from the execute-stage branch comparator. Fetch queries it with the current PC and gets a direction and target prediction. Execute later returns the resolved outcome and target for each conditional branch, which trains the predictor. The block flags a mispredict and supplies the corrected fetch PC one cycle after resolution, and keeps running branch and mispredict counts.

## Interface
Parameters:
- ENTRIES, 64, number of table entries; power of two, at least 4. IDX_W = log2(ENTRIES); TAG_W = 30 - IDX_W.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_pc  in  32  fetch PC (word aligned)
- pred_hit  out  1  table entry valid and tag matches if_pc (combinational)
- pred_taken  out  1  predicted taken (combinational)
- pred_target  out  32  predicted next PC (combinational)
- ex_valid  in  1  a conditional branch resolves in execute this cycle
- ex_pc  in  32  PC of the resolving branch
- ex_taken  in  1  resolved direction (branch_taken from execute)
- ex_target  in  32  resolved taken target
- ex_pred_taken  in  1  prediction that was made for this branch, carried down the pipeline
- ex_pred_target  in  32  predicted target that was made for this branch, carried down the pipeline
- mispredict  out  1  registered one-cycle pulse; fetch must flush and redirect
- redirect_pc  out  32  registered corrected PC; valid when mispredict=1
- stat_branches  out  32  count of resolved branches
- stat_mispredicts  out  32  count of mispredicts

## Operation
- Per-entry state: valid (1), tag (TAG_W), target (32), ctr (2-bit saturating counter).
- Index and tag for any PC:
  - idx = pc[IDX_W+1:2]
  - tag = pc[31:IDX_W+2]
- Lookup (purely combinational from table flops):
  - pred_hit = valid[idx] && tag[idx] == tag(if_pc)
  - pred_taken = pred_hit && ctr[idx][1]
  - pred_target = pred_taken ? target[idx] : if_pc + 4 (32-bit wrap)
- Update on ex_valid, using idx and tag of ex_pc:
  - Entry hit, taken: ctr saturates upward (3 stays 3); target is overwritten with ex_target.
  - Entry hit, not taken: ctr saturates downward (0 stays 0); target is unchanged.
  - Miss, taken: allocate the entry, replacing any occupant. Set valid=1, write tag and target=ex_target, set ctr=2'b10 (weakly taken).
  - Miss, not taken: no change to the table.
- Mispredict condition: ex_valid && ((ex_pred_taken != ex_taken) || (ex_taken && ex_pred_taken && ex_pred_target != ex_target)).
- Registered outputs, next cycle:
  - mispredict is set from the mispredict condition.
  - If a mispredict occurred, redirect_pc = ex_taken ? ex_target : ex_pc + 4. Otherwise redirect_pc holds its previous value.
- Statistics:
  - stat_branches increments on every ex_valid.
  - stat_mispredicts increments on every mispredict condition.
  - Both counters wrap modulo 2^32.
- The table has no knowledge of instruction type. Only ex_valid qualifies updates; ex_* inputs are ignored when ex_valid=0.

## Timing
- Lookup latency is 0 cycles: if_pc to pred_* is combinational, with no internal register on the path.
- Update latency is 1 cycle: a lookup in cycle N+1 sees the training applied at the edge ending cycle N.
- Same index looked up and updated in one cycle: the lookup returns the pre-update contents. There is no bypass.
- mispredict and redirect_pc assert in the cycle after ex_valid. mispredict is high for exactly one cycle per mispredicting branch; back-to-back mispredicts give consecutive pulses.
- Reset (rst=1 at an edge) takes effect at that edge and applies regardless of an in-flight ex_valid, whose update is dropped:
  - all valid bits = 0 and all ctr = 2'b01
  - mispredict = 0, redirect_pc = 0, stat_branches = 0, stat_mispredicts = 0
- Tag and target contents after reset are don't-care but must never be observable while valid=0.
- After reset: pred_hit=0, pred_taken=0, pred_target=if_pc+4.

## Test plan
- Reset then lookup: apply rst, then drive if_pc=0x100 → pred_hit=0, pred_taken=0, pred_target=0x104; all stats=0, mispredict=0.
- Cold taken branch: resolve ex_pc=0x100, ex_taken=1, ex_target=0x80, ex_pred_taken=0.
  - Next cycle: mispredict=1, redirect_pc=0x80, stat_mispredicts=1.
  - A lookup of 0x100 then gives pred_hit=1, pred_taken=1, pred_target=0x80.
- Counter saturation: after allocation, train 0x100 taken three more times, then not-taken once → pred_taken still 1 (ctr 3→2). A second not-taken → pred_taken=0 (ctr 1), pred_target=0x104, pred_hit=1.
- Aliasing: with ENTRIES=64, allocate 0x100, then resolve taken at 0x200 (same idx, different tag) → lookup of 0x100 gives pred_hit=0; lookup of 0x200 hits with the new target.
- Wrong target: resolve ex_taken=1, ex_pred_taken=1, ex_pred_target=0x40, ex_target=0x80 → mispredict=1, redirect_pc=0x80. Also resolve a not-taken branch at 0xFFFFFFFC that was predicted taken → redirect_pc=0x00000000.
- Reset during update and counter wrap:
  - Assert rst in the same cycle as ex_valid=1 → table stays invalid and stats=0.
  - Preload stat_branches to 0xFFFFFFFF via a forced value, then issue one resolve → stat_branches=0.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor
// Direct-mapped dynamic branch predictor with a 2-bit saturating counter and
// a stored target per entry. Fetch looks up combinationally; execute trains
// the table and the block reports mispredicts one cycle after resolution.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   if_pc               fetch PC to look up
//   pred_hit            entry valid and tag matches if_pc
//   pred_taken          predicted taken
//   pred_target         predicted next PC (stored target or if_pc + 4)
//   ex_valid            a conditional branch resolves this cycle
//   ex_pc, ex_taken,    resolved branch PC, direction and taken target
//   ex_target
//   ex_pred_taken,      prediction originally made for that branch
//   ex_pred_target
//   mispredict          registered one-cycle flush/redirect pulse
//   redirect_pc         registered corrected fetch PC
//   stat_branches       resolved-branch count (wraps)
//   stat_mispredicts    mispredict count (wraps)
module branch_predictor #(
  parameter int ENTRIES = 64,
  localparam int IDX_W = $clog2(ENTRIES),
  localparam int TAG_W = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  logic [ENTRIES-1:0] valid_r;
  logic [TAG_W-1:0]   tag_r    [ENTRIES];
  logic [31:0]        target_r [ENTRIES];
  logic [1:0]         ctr_r    [ENTRIES];

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             ex_hit;
  logic             mis_cond;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[31:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[31:IDX_W+2];

  // Lookup: combinational from table state, no bypass of same-cycle training
  assign pred_hit    = valid_r[if_idx] && (tag_r[if_idx] == if_tag);
  assign pred_taken  = pred_hit && ctr_r[if_idx][1];
  assign pred_target = pred_taken ? target_r[if_idx] : if_pc + 32'd4;

  assign ex_hit   = valid_r[ex_idx] && (tag_r[ex_idx] == ex_tag);
  assign mis_cond = ex_valid &&
                    ((ex_pred_taken != ex_taken) ||
                     (ex_taken && ex_pred_taken && (ex_pred_target != ex_target)));

  // Training and registered outputs: visible the cycle after ex_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r          <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_r[i] <= 2'b01;
      mispredict       <= 1'b0;
      redirect_pc      <= 32'd0;
      stat_branches    <= 32'd0;
      stat_mispredicts <= 32'd0;
    end else begin
      mispredict <= mis_cond;
      if (mis_cond) begin
        redirect_pc      <= ex_taken ? ex_target : ex_pc + 32'd4;
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
      if (ex_valid) begin
        stat_branches <= stat_branches + 32'd1;
        if (ex_hit) begin
          ctr_r[ex_idx] <= ex_taken ? ctr_inc(ctr_r[ex_idx]) : ctr_dec(ctr_r[ex_idx]);
        end else if (ex_taken) begin
          valid_r[ex_idx] <= 1'b1;
          ctr_r[ex_idx]   <= 2'b10;
        end
      end
    end
  end

  // Tag/target payload: not reset, only observable through a valid entry
  always_ff @(posedge clk) begin
    if (!rst && ex_valid && ex_taken) begin
      target_r[ex_idx] <= ex_target;
      if (!ex_hit) tag_r[ex_idx] <= ex_tag;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES = 64).
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int checks = 0;
  int errors = 0;

  branch_predictor #(.ENTRIES(64)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
    ex_valid = 1'b1; ex_pc = pc; ex_taken = tk; ex_target = tgt;
    ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  task automatic lookup(input logic [31:0] pc);
    if_pc = pc;
    #1;
  endtask

  initial begin
    rst = 1'b1; if_pc = 32'd0; ex_valid = 1'b0; ex_pc = 32'd0; ex_taken = 1'b0;
    ex_target = 32'd0; ex_pred_taken = 1'b0; ex_pred_target = 32'd0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    lookup(32'h100);
    chk("rst_hit", {31'd0, pred_hit}, 32'd0);
    chk("rst_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst_target", pred_target, 32'h104);
    chk("rst_mis", {31'd0, mispredict}, 32'd0);
    chk("rst_redirect", redirect_pc, 32'd0);
    chk("rst_br", stat_branches, 32'd0);
    chk("rst_mcnt", stat_mispredicts, 32'd0);

    // Cold taken branch allocates at ctr=2
    resolve(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    tick(); ex_valid = 1'b0;
    chk("cold_mis", {31'd0, mispredict}, 32'd1);
    chk("cold_redirect", redirect_pc, 32'h80);
    chk("cold_mcnt", stat_mispredicts, 32'd1);
    chk("cold_br", stat_branches, 32'd1);
    lookup(32'h100);
    chk("cold_hit", {31'd0, pred_hit}, 32'd1);
    chk("cold_taken", {31'd0, pred_taken}, 32'd1);
    chk("cold_target", pred_target, 32'h80);

    // Three correct taken predictions saturate ctr at 3
    resolve(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    tick(); tick(); tick(); ex_valid = 1'b0;
    chk("sat_mis", {31'd0, mispredict}, 32'd0);
    chk("sat_redirect_hold", redirect_pc, 32'h80);
    chk("sat_br", stat_branches, 32'd4);
    chk("sat_mcnt", stat_mispredicts, 32'd1);

    // Not-taken: ctr 3 -> 2, still predicts taken
    resolve(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    tick(); ex_valid = 1'b0;
    chk("nt1_mis", {31'd0, mispredict}, 32'd1);
    chk("nt1_redirect", redirect_pc, 32'h104);
    lookup(32'h100);
    chk("nt1_taken", {31'd0, pred_taken}, 32'd1);

    // Second not-taken back to back: ctr 2 -> 1, consecutive pulse
    resolve(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    tick(); ex_valid = 1'b0;
    chk("nt2_mis", {31'd0, mispredict}, 32'd1);
    chk("nt2_mcnt", stat_mispredicts, 32'd3);
    lookup(32'h100);
    chk("nt2_hit", {31'd0, pred_hit}, 32'd1);
    chk("nt2_taken", {31'd0, pred_taken}, 32'd0);
    chk("nt2_target", pred_target, 32'h104);

    // Same-cycle lookup sees pre-update state; then ctr 1 -> 2, new target
    resolve(32'h100, 1'b1, 32'h90, 1'b0, 32'h104);
    lookup(32'h100);
    chk("nobypass_taken", {31'd0, pred_taken}, 32'd0);
    tick(); ex_valid = 1'b0;
    chk("retrain_redirect", redirect_pc, 32'h90);
    lookup(32'h100);
    chk("retrain_taken", {31'd0, pred_taken}, 32'd1);
    chk("retrain_target", pred_target, 32'h90);
    chk("retrain_br", stat_branches, 32'd7);

    // Aliasing: 0x200 shares idx 0 with 0x100
    resolve(32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
    tick(); ex_valid = 1'b0;
    lookup(32'h100);
    chk("alias_old_hit", {31'd0, pred_hit}, 32'd0);
    chk("alias_old_target", pred_target, 32'h104);
    lookup(32'h200);
    chk("alias_new_hit", {31'd0, pred_hit}, 32'd1);
    chk("alias_new_target", pred_target, 32'h300);
    chk("alias_mcnt", stat_mispredicts, 32'd5);

    // Wrong target with correct direction
    resolve(32'h200, 1'b1, 32'h80, 1'b1, 32'h40);
    tick(); ex_valid = 1'b0;
    chk("wtgt_mis", {31'd0, mispredict}, 32'd1);
    chk("wtgt_redirect", redirect_pc, 32'h80);

    // Not-taken at top of address space: fall-through wraps to 0
    resolve(32'hFFFF_FFFC, 1'b0, 32'h1234, 1'b1, 32'h1234);
    tick(); ex_valid = 1'b0;
    chk("wrap_mis", {31'd0, mispredict}, 32'd1);
    chk("wrap_redirect", redirect_pc, 32'd0);
    chk("wrap_br", stat_branches, 32'd10);
    lookup(32'hFFFF_FFFC);
    chk("wrap_hit", {31'd0, pred_hit}, 32'd0);
    chk("wrap_target", pred_target, 32'd0);

    // ex_* ignored without ex_valid
    ex_pc = 32'h400; ex_taken = 1'b0; ex_pred_taken = 1'b1; ex_target = 32'h500;
    tick();
    chk("idle_mis", {31'd0, mispredict}, 32'd0);
    chk("idle_redirect", redirect_pc, 32'd0);
    chk("idle_br", stat_branches, 32'd10);
    chk("idle_mcnt", stat_mispredicts, 32'd7);

    // Reset in the same cycle as an update drops the update
    rst = 1'b1;
    resolve(32'h400, 1'b1, 32'h500, 1'b0, 32'h404);
    tick(); rst = 1'b0; ex_valid = 1'b0;
    chk("rstupd_br", stat_branches, 32'd0);
    chk("rstupd_mcnt", stat_mispredicts, 32'd0);
    chk("rstupd_mis", {31'd0, mispredict}, 32'd0);
    chk("rstupd_redirect", redirect_pc, 32'd0);
    lookup(32'h400);
    chk("rstupd_hit400", {31'd0, pred_hit}, 32'd0);
    lookup(32'h200);
    chk("rstupd_hit200", {31'd0, pred_hit}, 32'd0);
    chk("rstupd_target200", pred_target, 32'h204);

    // Branch counter wraps modulo 2^32
    force dut.stat_branches = 32'hFFFF_FFFF;
    tick();
    release dut.stat_branches;
    #1;
    chk("preload_br", stat_branches, 32'hFFFF_FFFF);
    resolve(32'h500, 1'b0, 32'h0, 1'b0, 32'h504);
    tick(); ex_valid = 1'b0;
    chk("cntwrap_br", stat_branches, 32'd0);
    chk("cntwrap_mcnt", stat_mispredicts, 32'd0);
    chk("cntwrap_mis", {31'd0, mispredict}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
